// File: rtl/adc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adc_pkg                                                      |
// | Description : Shared definitions for the ADC display path: FSM state       |
// |               encoding, default timing parameters, sample bus width and a  |
// |               low-bit mask helper. Also imported by the BCD stage.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_QUIET = 3'd4
    } adc_state_e;

    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam int unsigned DEF_DATA_BITS = 12;
    localparam int unsigned DEF_QUIET_CYC = 20;
    localparam int unsigned SAMPLE_W      = 16;

    // Mask with the low 'bits' positions set; used to zero-extend a result.
    function automatic logic [SAMPLE_W-1:0] low_mask(input int unsigned bits);
        logic [SAMPLE_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < SAMPLE_W; i++) begin
            m[i] = (i < bits);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_spi_reader_sclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adc_sclk_gen                                                 |
// | Description : SPI-mode-0 serial clock generator. Half-period counter,      |
// |               registered SCLK toggle, rise/fall ticks (asserted in the     |
// |               cycle before the corresponding SCLK edge) and a bit counter. |
// |               Held cleared (SCLK low) whenever en_i is low.                |
// | Ports       : clk, rst_n      - clock, async active-low reset              |
// |               en_i            - run (high only in SHIFT)                   |
// |               sclk_o          - registered serial clock, idle low          |
// |               rise_tick_o     - next edge takes SCLK 0->1                  |
// |               fall_tick_o     - next edge takes SCLK 1->0                  |
// |               last_bit_o      - current SCLK period is the final bit       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module adc_sclk_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned DATA_BITS = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic sclk_o,
    output logic rise_tick_o,
    output logic fall_tick_o,
    output logic last_bit_o
);

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST  = 5'(DATA_BITS - 1);

    logic [7:0] half_cnt_q, half_cnt_d;
    logic [4:0] bit_cnt_q,  bit_cnt_d;
    logic       sclk_q,     sclk_d;
    logic       w_half_end;

    assign w_half_end  = en_i && (half_cnt_q == HALF_LAST);
    assign rise_tick_o = w_half_end && !sclk_q;
    assign fall_tick_o = w_half_end &&  sclk_q;
    assign last_bit_o  = (bit_cnt_q == BIT_LAST);
    assign sclk_o      = sclk_q;

    always_comb begin
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        if (!en_i) begin
            half_cnt_d = '0;
            bit_cnt_d  = '0;
            sclk_d     = 1'b0;
        end else if (w_half_end) begin
            half_cnt_d = '0;
            sclk_d     = ~sclk_q;
            // A bit period ends with its high phase.
            if (sclk_q) begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end
        end else begin
            half_cnt_d = half_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_spi_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adc_spi_reader                                               |
// | Description : Reads a serial SPI-mode-0 ADC: frames cs_n, clocks in        |
// |               DATA_BITS bits MSB-first and presents the result             |
// |               right-justified on a 16-bit bus with a one-cycle strobe.     |
// |               Conversions repeat while en is high.                         |
// | Ports       : clk, rst_n      - clock, async active-low reset              |
// |               en              - level, run conversions                     |
// |               adc_miso        - ADC serial data                            |
// |               adc_cs_n        - ADC chip select (registered)               |
// |               adc_sclk        - ADC serial clock (registered, idle low)    |
// |               sample          - last completed result, zero-extended       |
// |               sample_valid    - one-cycle pulse when sample updates        |
// |               busy            - high outside IDLE                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned DATA_BITS = DEF_DATA_BITS,
    parameter int unsigned QUIET_CYC = DEF_QUIET_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                adc_miso,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                busy
);

    generate
        if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("adc_spi_reader: CLK_DIV=%0d outside 2..255", CLK_DIV);
        end
        if (DATA_BITS < 1 || DATA_BITS > SAMPLE_W) begin : g_bad_data_bits
            $error("adc_spi_reader: DATA_BITS=%0d outside 1..16", DATA_BITS);
        end
        if (QUIET_CYC < 1 || QUIET_CYC > 65535) begin : g_bad_quiet_cyc
            $error("adc_spi_reader: QUIET_CYC=%0d outside 1..65535", QUIET_CYC);
        end
    endgenerate

    localparam logic [15:0]         SETUP_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0]         QUIET_LAST  = 16'(QUIET_CYC - 1);
    localparam logic [SAMPLE_W-1:0] RESULT_MASK = low_mask(DATA_BITS);

    adc_state_e          state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                cs_n_q, cs_n_d;
    logic                w_rise, w_fall, w_last;

    adc_sclk_gen #(
        .CLK_DIV   (CLK_DIV),
        .DATA_BITS (DATA_BITS)
    ) u_sclk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (state_q == ST_SHIFT),
        .sclk_o      (adc_sclk),
        .rise_tick_o (w_rise),
        .fall_tick_o (w_fall),
        .last_bit_o  (w_last)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                shift_d = '0;
                if (en) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SHIFT: begin
                // Shift on the edge that raises SCLK. Bits above DATA_BITS
                // are stale and masked off when the result is published.
                if (w_rise) begin
                    shift_d = {shift_q[SAMPLE_W-2:0], adc_miso};
                end
                if (w_fall && w_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_QUIET;
            end
            ST_QUIET: begin
                if (cnt_q == QUIET_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        valid_d  = (state_d == ST_DONE);
        sample_d = valid_d ? (shift_q & RESULT_MASK) : sample_q;
        cs_n_d   = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            cs_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            cs_n_q   <= cs_n_d;
        end
    end

    assign adc_cs_n     = cs_n_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_adc_spi_reader                                            |
// | Description : Self-checking bench. Instance 0 uses default parameters,     |
// |               instance 1 uses CLK_DIV=2, DATA_BITS=8, QUIET_CYC=5. Each    |
// |               has a serial ADC model; frames are checked against expected  |
// |               values derived from word, bit count and clock divider.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_adc_spi_reader;

    int cd [2] = '{4, 2};
    int db [2] = '{12, 8};
    int qc [2] = '{20, 5};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en [2];
    logic        miso [2];
    logic        cs_n [2];
    logic        sclk [2];
    logic        valid [2];
    logic        busy [2];
    logic [15:0] sample [2];

    adc_spi_reader dut0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .adc_miso(miso[0]),
        .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]), .sample(sample[0]),
        .sample_valid(valid[0]), .busy(busy[0])
    );

    adc_spi_reader #(.CLK_DIV(2), .DATA_BITS(8), .QUIET_CYC(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .adc_miso(miso[1]),
        .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]), .sample(sample[1]),
        .sample_valid(valid[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int fails   = 0;

    // ADC model and bus monitor state
    logic [15:0] adc_word [2];
    int          bidx [2];
    logic        p_cs [2], p_sclk [2], p_valid [2];
    int          low_len [2], last_low [2], high_len [2], last_high [2];
    int          rises [2], last_rises [2];
    int          vcount [2], vcyc [2], dbl [2], sclk_bad [2];
    logic [15:0] vsample [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; miso[i] = 1'b0; adc_word[i] = '0; bidx[i] = 0;
            p_cs[i] = 1'b1; p_sclk[i] = 1'b0; p_valid[i] = 1'b0;
            low_len[i] = 0; last_low[i] = 0; high_len[i] = 0; last_high[i] = 0;
            rises[i] = 0; last_rises[i] = 0; vcount[i] = 0; vcyc[i] = 0;
            dbl[i] = 0; sclk_bad[i] = 0; vsample[i] = '0;
        end
    end

    // The ADC presents its MSB when cs_n falls and the next bit after each
    // SCLK falling edge. Bus statistics are gathered on the same sample.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (p_cs[i] && !cs_n[i]) begin
                last_high[i] = high_len[i];
                low_len[i]   = 0;
                rises[i]     = 0;
                bidx[i]      = db[i] - 1;
                miso[i]      = adc_word[i][bidx[i]];
            end else if (!cs_n[i] && p_sclk[i] && !sclk[i]) begin
                bidx[i] = bidx[i] - 1;
                miso[i] = (bidx[i] >= 0) ? adc_word[i][bidx[i]] : 1'b0;
            end
            if (!p_cs[i] && cs_n[i]) begin
                last_low[i]   = low_len[i];
                last_rises[i] = rises[i];
                high_len[i]   = 0;
            end
            if (cs_n[i]) begin
                high_len[i] = high_len[i] + 1;
                if (sclk[i]) sclk_bad[i] = sclk_bad[i] + 1;
            end else begin
                low_len[i] = low_len[i] + 1;
                if (sclk[i] && !p_sclk[i]) rises[i] = rises[i] + 1;
            end
            if (valid[i]) begin
                if (p_valid[i]) dbl[i] = dbl[i] + 1;
                vcount[i]  = vcount[i] + 1;
                vcyc[i]    = cyc;
                vsample[i] = sample[i];
            end
            p_cs[i]    = cs_n[i];
            p_sclk[i]  = sclk[i];
            p_valid[i] = valid[i];
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (busy[i] && n < 5000) begin tick(); n++; end
        check("idle_wait", busy[i], 0);
    endtask

    task automatic wait_valid(input int i, input int v0);
        int n = 0;
        while (vcount[i] == v0 && n < 3000) begin tick(); n++; end
        check("valid_seen", vcount[i] - v0, 1);
    endtask

    // Reference model: expectations follow from the frame rules directly.
    typedef struct {
        int          dut;
        logic [15:0] word;
        int          hold;
        logic [15:0] exp_sample;
        int          exp_low;
        int          exp_rises;
    } vec_t;

    function automatic vec_t make_vec(input int d, input logic [15:0] w, input int hold);
        vec_t v;
        v.dut        = d;
        v.word       = w;
        v.exp_sample = 16'(32'(w) % (32'd1 << db[d]));
        v.exp_low    = cd[d] + 2 * cd[d] * db[d];
        v.exp_rises  = db[d];
        v.hold       = (hold < 1) ? 1 : ((hold > v.exp_low) ? v.exp_low : hold);
        return v;
    endfunction

    task automatic run_frame(input vec_t v);
        int i, v0, ecyc;
        i = v.dut;
        wait_idle(i);
        adc_word[i] = v.word;
        @(negedge clk);
        en[i] = 1'b1;
        v0 = vcount[i];
        @(posedge clk);
        #1 ecyc = cyc;
        repeat (v.hold - 1) @(negedge clk);
        @(negedge clk);
        en[i] = 1'b0;
        #1;
        wait_valid(i, v0);
        check("sample", vsample[i], v.exp_sample);
        check("valid_latency", vcyc[i] - ecyc, v.exp_low);
        check("cs_low_cycles", last_low[i], v.exp_low);
        check("sclk_rises", last_rises[i], v.exp_rises);
        repeat (qc[i]) tick();
        check("busy_in_quiet", busy[i], 1);
        tick();
        check("busy_after_quiet", busy[i], 0);
        repeat (10) tick();
        check("single_frame", vcount[i] - v0, 1);
        check("sample_hold", sample[i], v.exp_sample);
    endtask

    vec_t tbl [10];

    initial begin : main
        int bad, v0, t1, exp_low0;
        logic [15:0] w;
        vec_t vr;

        tbl[0] = make_vec(0, 16'h0ABC, 100);
        tbl[1] = make_vec(0, 16'h0123, 1);
        tbl[2] = make_vec(1, 16'h00A5, 34);
        tbl[3] = make_vec(1, 16'hFF5A, 1);
        for (int k = 4; k < 10; k++) begin
            int d;
            d = int'($urandom_range(0, 1));
            tbl[k] = make_vec(d, 16'($urandom), int'($urandom_range(1, 120)));
        end
        exp_low0 = cd[0] + 2 * cd[0] * db[0];

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs_n", cs_n[0], 1);
        check("rst_sclk", sclk[0], 0);
        check("rst_sample", sample[0], 0);
        check("rst_valid", valid[0], 0);
        check("rst_busy", busy[0], 0);
        rst_n = 1'b1;

        // Idle with en low
        bad = 0;
        for (int k = 0; k < 500; k++) begin
            tick();
            for (int i = 0; i < 2; i++)
                if (!cs_n[i] || sclk[i] || busy[i] || valid[i]) bad++;
        end
        check("idle_quiet_bus", bad, 0);
        check("idle_no_valid", vcount[0] + vcount[1], 0);

        // Table-driven frames
        for (int k = 0; k < 10; k++) run_frame(tbl[k]);

        // Continuous enable: back-to-back frames
        wait_idle(0);
        adc_word[0] = 16'h0FFF;
        @(negedge clk);
        en[0] = 1'b1;
        v0 = vcount[0];
        wait_valid(0, v0);
        check("cont_sample0", vsample[0], 16'h0FFF);
        t1 = vcyc[0];
        adc_word[0] = 16'h0000;
        wait_valid(0, v0 + 1);
        en[0] = 1'b0;
        check("cont_sample1", vsample[0], 16'h0000);
        check("cont_period", vcyc[0] - t1, exp_low0 + 1 + qc[0] + 1);
        check("cont_cs_high", last_high[0], qc[0] + 2);

        // Reset in the middle of a frame
        run_frame(make_vec(0, 16'h0ABC, 1));
        w = 16'($urandom);
        adc_word[0] = w;
        @(negedge clk);
        en[0] = 1'b1;
        begin
            int n = 0;
            while (!(rises[0] == 6 && !cs_n[0]) && n < 1000) begin @(negedge clk); n++; end
        end
        v0 = vcount[0];
        rst_n = 1'b0;
        #1;
        check("midrst_cs_n", cs_n[0], 1);
        check("midrst_sclk", sclk[0], 0);
        check("midrst_sample", sample[0], 0);
        check("midrst_busy", busy[0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_no_valid", vcount[0] - v0, 0);
        wait_valid(0, v0);
        en[0] = 1'b0;
        vr = make_vec(0, w, 1);
        check("midrst_recover", vsample[0], vr.exp_sample);
        check("midrst_rises", last_rises[0], 12);
        wait_idle(0);

        check("valid_width", dbl[0] + dbl[1], 0);
        check("sclk_outside_cs", sclk_bad[0] + sclk_bad[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
